// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO read side and the packed output stream of fifo_word_packer.
//
// Handshakes:
//   FIFO side   - a read is accepted in any cycle where fifo_rd_en & !fifo_empty;
//                 fifo_rd_data carries that word during the following cycle.
//   Output side - a word transfers on every rising clk edge where out_valid & out_ready;
//                 while out_valid is high and out_ready is low, out_data/out_keep/out_last
//                 are held stable, and out_valid never drops without a transfer.
interface fifo_word_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic [IN_WIDTH-1:0]       fifo_rd_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [IN_WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]          out_keep;
    logic                      out_last;

    // Packer side: reads the FIFO, drives the packed stream.
    modport master (
        input  fifo_empty, fifo_rd_data, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_keep, out_last
    );

    // Environment side: FIFO, flush source and downstream sink.
    modport slave (
        output fifo_empty, fifo_rd_data, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains narrow words from a FIFO and packs RATIO consecutive words
// into one wide word (lane 0 = oldest). A flush pulse closes a partial word, marking
// the filled lanes in out_keep and setting out_last.
module fifo_word_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input logic             clk,
    input logic             rst,
    fifo_word_packer_if.master bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CW        = $clog2(RATIO + 1);
    localparam int LW        = $clog2(RATIO);
    localparam logic [CW-1:0] FULL      = CW'(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]                 cnt;
    logic [CW-1:0]                 next_cnt;
    logic                          in_flight;
    logic                          flush_pending;
    logic [RATIO-1:0][IN_WIDTH-1:0] acc;

    logic                  out_free;
    logic                  full;
    logic                  xfer;
    logic                  pre_xfer;
    logic                  room;
    logic                  rd_en;
    logic                  part_emit;
    logic                  flush_done;
    logic [LW-1:0]         cap_idx;
    logic [RATIO-1:0]      part_keep;
    logic [OUT_WIDTH-1:0]  part_data;

    // Read issue, transfer decisions, capture lane and partial-word formatting.
    always_comb begin
        out_free = !bus.out_valid || bus.out_ready;
        full     = (cnt == FULL);
        xfer     = full && out_free;
        room     = ({1'b0, cnt} + {{CW{1'b0}}, in_flight}) < {1'b0, FULL};
        // Last lane is in flight and the output register is free now. Nothing can load
        // the output register this cycle (cnt < RATIO), so it is still free next cycle
        // and the transfer is certain: reading one word ahead keeps the stream bubble-free,
        // that word lands in lane 0 of the next word during the transfer.
        pre_xfer = (cnt == LAST_LANE) && in_flight && out_free;
        rd_en    = !rst && !bus.fifo_empty && !flush_pending && (room || xfer || pre_xfer);

        part_emit  = flush_pending && !in_flight && (cnt != '0) && !full && out_free;
        // A word still landing during a flushed full transfer keeps the flush alive so it
        // is closed by its own partial word.
        flush_done = flush_pending && !in_flight && ((cnt == '0) || part_emit || xfer);

        cap_idx = xfer ? '0 : cnt[LW-1:0];
        if (xfer || part_emit) begin
            next_cnt = {{(CW-1){1'b0}}, in_flight};
        end else begin
            next_cnt = cnt + {{(CW-1){1'b0}}, in_flight};
        end

        part_keep = '0;
        part_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            part_keep[i] = (CW'(i) < cnt);
            part_data[i*IN_WIDTH +: IN_WIDTH] = part_keep[i] ? acc[i] : '0;
        end
    end

    assign bus.fifo_rd_en = rd_en;

    // Lane count, in-flight tracking and flush request state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            in_flight     <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            cnt       <= next_cnt;
            in_flight <= rd_en;
            if (flush_pending) begin
                if (flush_done) flush_pending <= 1'b0;
            end else if (bus.flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // Capture the word read last cycle into its lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (in_flight) begin
            acc[cap_idx] <= bus.fifo_rd_data;
        end
    end

    // Output register: load a full or flushed partial word, drop valid once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            bus.out_last  <= 1'b0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= acc;
            bus.out_keep  <= '1;
            bus.out_last  <= flush_pending;
        end else if (part_emit) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= part_data;
            bus.out_keep  <= part_keep;
            bus.out_last  <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: behavioural FIFO, expected-word scoreboard,
// a table of pack/flush vectors and hand-written multi-cycle sequences.
module tb_fifo_word_packer;
    localparam int IN_WIDTH  = 8;
    localparam int RATIO     = 4;
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int EW        = OUT_WIDTH + RATIO + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_word_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    fifo_word_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- FIFO model ----------------
    logic [IN_WIDTH-1:0] fifo_mem [0:255];
    int                  wr_ptr = 0;
    int                  rd_ptr = 0;
    logic [IN_WIDTH-1:0] rd_data_r = '0;

    assign bus.fifo_empty   = (rd_ptr == wr_ptr);
    assign bus.fifo_rd_data = rd_data_r;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            rd_data_r <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_w;
    logic [EW-1:0] exp_w;
    int n_checks  = 0;
    int n_fail    = 0;
    int out_count = 0;
    int rd_total  = 0;
    int rd_cyc [0:255];

    always @(negedge clk) begin
        #2;
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            rd_cyc[rd_total] = cyc;
            rd_total = rd_total + 1;
        end
        if (bus.out_valid && bus.out_ready) begin
            out_count = out_count + 1;
            n_checks  = n_checks + 1;
            got_w = {bus.out_data, bus.out_keep, bus.out_last};
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL out_word: got data=%h keep=%b last=%b, required no output",
                         bus.out_data, bus.out_keep, bus.out_last);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out_word: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                             bus.out_data, bus.out_keep, bus.out_last,
                             exp_w[EW-1 -: OUT_WIDTH], exp_w[RATIO:1], exp_w[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks = n_checks + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push_word(input logic [IN_WIDTH-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [OUT_WIDTH-1:0] d, input logic [RATIO-1:0] k,
                               input logic l);
        exp_q.push_back({d, k, l});
    endtask

    // Called on a falling edge; flush is high for exactly one rising edge.
    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                   n;
        logic [OUT_WIDTH-1:0] words;
        bit                   do_flush;
        logic [OUT_WIDTH-1:0] exp_data;
        logic [RATIO-1:0]     exp_keep;
        bit                   exp_last;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int ocnt;
        logic [IN_WIDTH-1:0]  v;
        logic [OUT_WIDTH-1:0] wd [3];
        logic [IN_WIDTH-1:0]  t3w [10];

        tbl[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF,    1'b0};
        tbl[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'b0011, 1'b1};
        tbl[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
        tbl[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'b0111, 1'b1};
        tbl[4] = '{4, 32'hEFBEADDE, 1'b1, 32'hEFBEADDE, 4'hF,    1'b0};

        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_keep",  64'(bus.out_keep),  64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_rd_en",     64'(bus.fifo_rd_en), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // table: full words, flushed partial words, flush after a full word
        for (int r = 0; r < 5; r++) begin
            base = rd_total;
            ocnt = out_count;
            expect_word(tbl[r].exp_data, tbl[r].exp_keep, tbl[r].exp_last);
            for (int i = 0; i < tbl[r].n; i++) push_word(tbl[r].words[i*IN_WIDTH +: IN_WIDTH]);
            repeat (tbl[r].n + 4) @(negedge clk);
            if (tbl[r].do_flush) pulse_flush();
            wait_drain($sformatf("tbl%0d_drain", r));
            repeat (4) @(negedge clk);
            check($sformatf("tbl%0d_out_count", r), 64'(out_count - ocnt), 64'd1);
            check($sformatf("tbl%0d_reads", r), 64'(rd_total - base), 64'(tbl[r].n));
            if (tbl[r].n > 1)
                check($sformatf("tbl%0d_read_span", r),
                      64'(rd_cyc[base + tbl[r].n - 1] - rd_cyc[base]), 64'(tbl[r].n - 1));
        end

        // T2: 12 random words streamed, no bubble at the transfers
        base = rd_total;
        ocnt = out_count;
        for (int w = 0; w < 12; w++) begin
            v = IN_WIDTH'($urandom_range(0, 255));
            wd[w / 4][(w % 4) * IN_WIDTH +: IN_WIDTH] = v;
            push_word(v);
        end
        for (int k = 0; k < 3; k++) expect_word(wd[k], 4'hF, 1'b0);
        wait_drain("stream_drain");
        repeat (3) @(negedge clk);
        check("stream_reads", 64'(rd_total - base), 64'd12);
        check("stream_read_span", 64'(rd_cyc[base + 11] - rd_cyc[base]), 64'd11);
        check("stream_out_count", 64'(out_count - ocnt), 64'd3);

        // T3: backpressure stops reads after two words are buffered
        bus.out_ready = 1'b0;
        base = rd_total;
        ocnt = out_count;
        for (int w = 0; w < 10; w++) begin
            t3w[w] = IN_WIDTH'($urandom_range(0, 255));
            push_word(t3w[w]);
        end
        expect_word({t3w[3], t3w[2], t3w[1], t3w[0]}, 4'hF, 1'b0);
        expect_word({t3w[7], t3w[6], t3w[5], t3w[4]}, 4'hF, 1'b0);
        expect_word({16'h0000, t3w[9], t3w[8]}, 4'b0011, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check("bp_reads", 64'(rd_total - base), 64'd8);
        check("bp_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_data", 64'(bus.out_data), 64'({t3w[3], t3w[2], t3w[1], t3w[0]}));
        bus.out_ready = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("bp_reads_after", 64'(rd_total - base), 64'd10);
        pulse_flush();
        wait_drain("bp_drain");
        check("bp_out_count", 64'(out_count - ocnt), 64'd3);

        // T5a: flush with nothing buffered produces nothing
        ocnt = out_count;
        pulse_flush();
        repeat (10) @(negedge clk);
        check("idle_flush_out_count", 64'(out_count - ocnt), 64'd0);
        check("idle_flush_valid", 64'(bus.out_valid), 64'd0);

        // FIFO empty mid-word: the partial word waits; then flush in the cycle a read is accepted
        push_word(8'h31);
        push_word(8'h32);
        repeat (20) @(negedge clk);
        check("midword_wait", 64'(out_count - ocnt), 64'd0);
        expect_word(32'h00333231, 4'b0111, 1'b1);
        push_word(8'h33);
        bus.flush = 1'b1;
        #1;
        check("flush_same_cycle_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        wait_drain("flush_capture_drain");
        repeat (3) @(negedge clk);
        check("flush_capture_out_count", 64'(out_count - ocnt), 64'd1);

        // T6: reset with cnt=3 and a held output word
        bus.out_ready = 1'b0;
        base = rd_total;
        for (int w = 0; w < 7; w++) push_word(IN_WIDTH'($urandom_range(0, 255)));
        repeat (15) @(negedge clk);
        check("pre_rst_reads", 64'(rd_total - base), 64'd7);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        push_word(8'h5C);
        #1;
        check("in_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_data",  64'(bus.out_data),  64'd0);
        check("mid_rst_out_keep",  64'(bus.out_keep),  64'd0);
        check("mid_rst_out_last",  64'(bus.out_last),  64'd0);
        check("mid_rst_rd_en",     64'(bus.fifo_rd_en), 64'd0);
        ocnt = out_count;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        expect_word(32'h0000005C, 4'b0001, 1'b1);
        repeat (6) @(negedge clk);
        pulse_flush();
        wait_drain("post_rst_drain");
        repeat (3) @(negedge clk);
        check("post_rst_out_count", 64'(out_count - ocnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
